// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide unit: one shift-add or restoring-divide step per
// cycle on operand magnitudes, with the sign fix-up applied when HI/LO are written.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_dbg
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic             is_div, sign_a, neg, b_zero;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic [WIDTH-1:0] mag_in_a, mag_in_b;
    logic [WIDTH:0]   add_sum, shifted, acc_nx;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] q_nx;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0] quo_s, rem_s, hi_nx, lo_nx;

    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign accept    = (state == IDLE) && start && (op == 2'b01 || op == 2'b10);

    // An unsigned WIDTH-bit magnitude holds |most-negative| exactly.
    assign mag_in_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign mag_in_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // acc:q is the {upper,lower} product for mult and {remainder,quotient} for div.
    always_comb begin
        add_sum = q[0] ? (acc + {1'b0, mag_a}) : acc;
        shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, mag_b};
        acc_nx  = {1'b0, add_sum[WIDTH:1]};
        q_nx    = {add_sum[0], q[WIDTH-1:1]};
        if (is_div) begin
            if (!trial[WIDTH+1]) begin
                acc_nx = trial[WIDTH:0];
                q_nx   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = shifted;
                q_nx   = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod   = {acc[WIDTH-1:0], q};
        prod_s = neg ? (~prod + 1'b1) : prod;
        quo_s  = neg ? (~q + 1'b1) : q;
        rem_s  = sign_a ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        hi_nx  = prod_s[2*WIDTH-1:WIDTH];
        lo_nx  = prod_s[WIDTH-1:0];
        if (is_div) begin
            // Divide by zero leaves remainder = |a|, so hi already equals a.
            hi_nx = rem_s;
            lo_nx = b_zero ? '1 : quo_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_div <= 1'b0;
            sign_a <= 1'b0;
            neg    <= 1'b0;
            b_zero <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc    <= '0;
            q      <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (accept) begin
                is_div <= (op == 2'b10);
                sign_a <= a[WIDTH-1];
                neg    <= a[WIDTH-1] ^ b[WIDTH-1];
                b_zero <= (b == '0);
                mag_a  <= mag_in_a;
                mag_b  <= mag_in_b;
                acc    <= '0;
                q      <= (op == 2'b10) ? mag_in_a : mag_in_b;
                cnt    <= '0;
            end else if (state == CALC) begin
                acc <= acc_nx;
                q   <= q_nx;
                cnt <= cnt + CW'(1);
            end else if (state == FIX) begin
                hi <= hi_nx;
                lo <= lo_nx;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: reset, signed mult/div results, boundary operands,
// back-to-back issue, ignored restart and mid-operation reset.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;
    logic [1:0]   state_dbg;

    int pass_cnt = 0;
    int total_cnt = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Driver: issue at a negedge, return at the negedge where done is seen.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] h, output logic [W-1:0] l,
                          output logic [W-1:0] mid_h, output logic [W-1:0] mid_l,
                          output int busy_n, output bit timed_out);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 2'b00;
        busy_n = 0; timed_out = 1'b1; h = '0; l = '0; mid_h = '0; mid_l = '0;
        for (int i = 1; i <= 100; i++) begin
            if (busy) busy_n++;
            if (i == 10) begin mid_h = hi; mid_l = lo; end
            if (done) begin
                h = hi; l = lo; timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        @(negedge clk); @(negedge clk);
        total_cnt++;
        if ({busy, done, hi, lo, state_dbg} !== {1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}, 2'b00})
            $display("FAIL reset: busy=%0b done=%0b hi=%h lo=%h st=%0d, need all zero", busy, done, hi, lo, state_dbg);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nop();
        int busy_seen = 0;
        op = 2'b11; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        op = 2'b00;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy) busy_seen++;
            @(negedge clk);
        end
        total_cnt++;
        if (busy_seen !== 0) $display("FAIL nop_ignored: busy cycles=%0d, need 0", busy_seen);
        else pass_cnt++;
    endtask

    task automatic test_div_basic();
        logic [W-1:0] h, l, mh, ml; int bn; bit to;
        run_op(2'b10, 32'd14, 32'd2, h, l, mh, ml, bn, to);
        total_cnt++;
        if (to) $display("FAIL div14_2_timeout: no done within 100 cycles");
        else pass_cnt++;
        total_cnt++;
        if ({h, l} !== {32'd0, 32'd7}) $display("FAIL div14_2: hi=%h lo=%h, need hi=0 lo=7", h, l);
        else pass_cnt++;
        total_cnt++;
        if (bn !== W + 1) $display("FAIL div14_2_busy: busy cycles=%0d, need %0d", bn, W + 1);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0) $display("FAIL done_one_cycle: done=%0b, need 0", done);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] h, l, mh, ml; int bn; bit to;
        run_op(2'b01, 32'd3, 32'd3, h, l, mh, ml, bn, to);
        total_cnt++;
        if (to || {h, l} !== {32'd0, 32'd9}) $display("FAIL mult3_3: hi=%h lo=%h to=%0b, need hi=0 lo=9", h, l, to);
        else pass_cnt++;
        // Issue immediately while done is high.
        run_op(2'b10, -32'sd7, 32'd2, h, l, mh, ml, bn, to);
        total_cnt++;
        if (to || {h, l} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD})
            $display("FAIL div_m7_2: hi=%h lo=%h to=%0b, need hi=ffffffff lo=fffffffd", h, l, to);
        else pass_cnt++;
        total_cnt++;
        if ({mh, ml} !== {32'd0, 32'd9}) $display("FAIL hold_during_calc: hi=%h lo=%h, need hi=0 lo=9", mh, ml);
        else pass_cnt++;
        total_cnt++;
        if (bn !== W + 1) $display("FAIL b2b_busy: busy cycles=%0d, need %0d", bn, W + 1);
        else pass_cnt++;
    endtask

    task automatic test_mult_edge();
        logic [W-1:0] h, l, mh, ml; int bn; bit to;
        run_op(2'b01, 32'h8000_0000, 32'd2, h, l, mh, ml, bn, to);
        total_cnt++;
        if (to || {h, l} !== {32'hFFFF_FFFF, 32'h0000_0000})
            $display("FAIL mult_minneg_2: hi=%h lo=%h, need hi=ffffffff lo=00000000", h, l);
        else pass_cnt++;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, mh, ml, bn, to);
        total_cnt++;
        if (to || {h, l} !== {32'd0, 32'd1}) $display("FAIL mult_m1_m1: hi=%h lo=%h, need hi=0 lo=1", h, l);
        else pass_cnt++;
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, h, l, mh, ml, bn, to);
        total_cnt++;
        if (to || {h, l} !== {32'h4000_0000, 32'd0})
            $display("FAIL mult_minneg_sq: hi=%h lo=%h, need hi=40000000 lo=0", h, l);
        else pass_cnt++;
        run_op(2'b01, 32'd100000, -32'sd3, h, l, mh, ml, bn, to);
        total_cnt++;
        if (to || {h, l} !== {32'hFFFF_FFFF, 32'hFFFB_6C20})
            $display("FAIL mult_pos_neg: hi=%h lo=%h, need hi=ffffffff lo=fffb6c20", h, l);
        else pass_cnt++;
    endtask

    task automatic test_div_edge();
        logic [W-1:0] h, l, mh, ml; int bn; bit to;
        run_op(2'b10, 32'd5, 32'd0, h, l, mh, ml, bn, to);
        total_cnt++;
        if (to || {h, l} !== {32'd5, 32'hFFFF_FFFF}) $display("FAIL div5_0: hi=%h lo=%h, need hi=5 lo=ffffffff", h, l);
        else pass_cnt++;
        total_cnt++;
        if (bn !== W + 1) $display("FAIL div0_busy: busy cycles=%0d, need %0d", bn, W + 1);
        else pass_cnt++;
        run_op(2'b10, -32'sd7, 32'd0, h, l, mh, ml, bn, to);
        total_cnt++;
        if (to || {h, l} !== {32'hFFFF_FFF9, 32'hFFFF_FFFF})
            $display("FAIL div_m7_0: hi=%h lo=%h, need hi=fffffff9 lo=ffffffff", h, l);
        else pass_cnt++;
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, h, l, mh, ml, bn, to);
        total_cnt++;
        if (to || {h, l} !== {32'd0, 32'h8000_0000})
            $display("FAIL div_overflow: hi=%h lo=%h, need hi=0 lo=80000000", h, l);
        else pass_cnt++;
        run_op(2'b10, 32'd7, -32'sd2, h, l, mh, ml, bn, to);
        total_cnt++;
        if (to || {h, l} !== {32'd1, 32'hFFFF_FFFD}) $display("FAIL div7_m2: hi=%h lo=%h, need hi=1 lo=fffffffd", h, l);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        int done_n = 0;
        logic [W-1:0] h = '0, l = '0;
        op = 2'b01; a = 32'h1234; b = 32'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 2'b00;
        for (int i = 1; i <= W + 10; i++) begin
            if (i == 10) begin start = 1'b1; op = 2'b10; a = 32'd1; b = 32'd1; end
            if (i == 11) begin start = 1'b0; op = 2'b00; end
            if (done) begin done_n++; h = hi; l = lo; end
            @(negedge clk);
        end
        total_cnt++;
        if (done_n !== 1) $display("FAIL restart_done_count: pulses=%0d, need 1", done_n);
        else pass_cnt++;
        total_cnt++;
        if ({h, l} !== {32'd0, 32'h0001_2340}) $display("FAIL restart_result: hi=%h lo=%h, need hi=0 lo=00012340", h, l);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int done_n = 0;
        logic [W-1:0] h, l, mh, ml; int bn; bit to;
        op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 2'b00;
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({busy, hi, lo} !== {1'b0, {W{1'b0}}, {W{1'b0}}})
            $display("FAIL reset_mid: busy=%0b hi=%h lo=%h, need all zero", busy, hi, lo);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 8; i++) begin
            if (done || busy) done_n++;
            @(negedge clk);
        end
        total_cnt++;
        if (done_n !== 0) $display("FAIL reset_mid_no_done: activity cycles=%0d, need 0", done_n);
        else pass_cnt++;
        run_op(2'b01, 32'd6, 32'd7, h, l, mh, ml, bn, to);
        total_cnt++;
        if (to || {h, l} !== {32'd0, 32'd42}) $display("FAIL post_reset_op: hi=%h lo=%h, need hi=0 lo=42", h, l);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_nop();
        test_div_basic();
        test_back_to_back();
        test_mult_edge();
        test_div_edge();
        test_start_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request from EXE, sampled on a rising clk edge.
REQ-005 The block SHALL have port op, input, 2 bits: 2'b01 = mult, 2'b10 = div, 2'b00 and 2'b11 = no operation.
REQ-006 The block SHALL have port a, input, WIDTH bits: rs operand, signed two's complement (multiplicand or dividend).
REQ-007 The block SHALL have port b, input, WIDTH bits: rt operand, signed two's complement (multiplier or divisor).
REQ-008 The block SHALL have port busy, output, 1 bit: operation in progress; the pipeline stalls mfhi/mflo while it is high.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO are updated.
REQ-010 The block SHALL have port hi, output, WIDTH bits: HI register, readable by mfhi.
REQ-011 The block SHALL have port lo, output, WIDTH bits: LO register, readable by mflo.

Function
REQ-012 The block SHALL implement three states: IDLE, CALC and FIX; state is registered.
REQ-013 busy SHALL equal (state != IDLE), decoded from the state register only.
REQ-014 In IDLE, start=1 with op 01 or 10 at edge k SHALL perform all of the following:
  - latch |a|, |b|, op and both operand signs;
  - clear the iteration counter;
  - go to CALC.
REQ-015 In IDLE, start=1 with op 00 or 11 SHALL be ignored, and the block SHALL stay in IDLE.
REQ-016 start SHALL be ignored while busy=1; no queuing and no abort.
REQ-017 CALC SHALL run exactly WIDTH iterations, one per edge (k+1 .. k+WIDTH), then go to FIX.
REQ-018 Mult SHALL be unsigned shift-add on magnitudes into a 2*WIDTH-bit product.
REQ-019 Div SHALL be unsigned restoring division on magnitudes, producing quotient and remainder.
REQ-020 At edge k+WIDTH+1 in FIX, the block SHALL write hi and lo and assert done for one cycle, then return to IDLE.
REQ-021 Total latency SHALL be WIDTH+1 edges after acceptance; busy SHALL be high for exactly WIDTH+1 cycles.
REQ-022 Mult result: the product SHALL be negated if sign(a) XOR sign(b); {hi,lo} = full signed 2*WIDTH-bit product.
REQ-023 Div result: lo = quotient truncated toward zero, negated if sign(a) XOR sign(b); hi = remainder carrying the sign of a.
REQ-024 Div by zero (b=0) SHALL produce hi = a and lo = all ones; it SHALL take the same latency as a normal div, with no exception.
REQ-025 Div overflow (a = most-negative, b = -1) SHALL produce lo = most-negative and hi = 0.
REQ-026 The most-negative operand SHALL be handled by using a WIDTH+1-bit magnitude or equivalent; no wrong result is allowed.
REQ-027 hi and lo SHALL hold their previous values throughout CALC; they change only at the FIX edge.
REQ-028 done SHALL be 0 in every state except the FIX->IDLE transition cycle.
REQ-029 Back-to-back operation: start may be asserted in the cycle immediately after done, and SHALL be accepted.

Reset
REQ-030 When rst=1, regardless of clk, the block SHALL force:
  - state = IDLE;
  - busy = 0, done = 0;
  - hi = 0, lo = 0;
  - iteration counter = 0.
REQ-031 Reset during CALC or FIX SHALL discard the operation with no partial write to hi or lo.
REQ-032 After rst falls, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-033 Scenario: div, a=14, b=2 -> after 33 cycles done=1, lo=7, hi=0; busy high for 33 cycles.
REQ-034 Scenario: mult, a=3, b=3 -> lo=9, hi=0; then div a=-7, b=2 started the cycle after done -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 Scenario: mult, a=0x80000000, b=2 -> hi=0xFFFFFFFF, lo=0x00000000; and mult a=-1, b=-1 -> hi=0, lo=1.
REQ-036 Scenario: div, a=5, b=0 -> hi=5, lo=0xFFFFFFFF; and div a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-037 Scenario: start pulsed again at cycle 10 of a running mult -> ignored; only the first result appears and done pulses once.
REQ-038 Scenario: rst=1 at cycle 15 of a div, asserted between clock edges -> busy=0, hi=0, lo=0 immediately; no done pulse follows.
